// File: rtl/aeolus_seq_pkg.sv
// Shared opcodes, sequencer states and the ALU-class helper for the Aeolus sequencer.
package aeolus_seq_pkg;

  localparam logic [3:0] OP_LDA  = 4'd0;
  localparam logic [3:0] OP_LDB  = 4'd1;
  localparam logic [3:0] OP_LDO  = 4'd2;
  localparam logic [3:0] OP_LDSA = 4'd3;
  localparam logic [3:0] OP_LDSB = 4'd4;
  localparam logic [3:0] OP_LSH  = 4'd5;
  localparam logic [3:0] OP_RSH  = 4'd6;
  localparam logic [3:0] OP_CLR  = 4'd7;
  localparam logic [3:0] OP_SNZA = 4'd8;
  localparam logic [3:0] OP_SNZS = 4'd9;
  localparam logic [3:0] OP_ADD  = 4'd10;
  localparam logic [3:0] OP_SUB  = 4'd11;
  localparam logic [3:0] OP_AND  = 4'd12;
  localparam logic [3:0] OP_OR   = 4'd13;
  localparam logic [3:0] OP_XOR  = 4'd14;
  localparam logic [3:0] OP_INV  = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } seq_state_e;

  // Opcodes whose result is written back into ACC: LDSA..RSH and ADD..INV.
  localparam logic [15:0] ALU_CLASS_MASK = 16'hFC78;

  function automatic logic op_is_alu(input logic [3:0] op);
    return ALU_CLASS_MASK[op];
  endfunction

endpackage

// File: rtl/aeolus_sequencer_if.sv
// Sequencer <-> ROM/datapath bus; AEOLUS_SEQ_BREAKPOINT_EN adds the breakpoint signals.
interface aeolus_sequencer_if #(
  parameter int PC_WIDTH = 4,
  parameter int OP_WIDTH = 4
);
  logic                     run_i;
  logic                     step_i;
  logic [OP_WIDTH-1:0]      opcode_i;
  logic                     skip_cond_i;
  logic [PC_WIDTH-1:0]      pc_o;
  logic [2**OP_WIDTH-1:0]   ctrl_o;
  logic                     acc_we_o;
  logic                     busy_o;
  logic                     halted_o;
  logic                     wrap_o;
`ifdef AEOLUS_SEQ_BREAKPOINT_EN
  logic                     bp_en_i;
  logic [PC_WIDTH-1:0]      bp_addr_i;
  logic                     bp_hit_o;

  modport slave (
    input  run_i, step_i, opcode_i, skip_cond_i, bp_en_i, bp_addr_i,
    output pc_o, ctrl_o, acc_we_o, busy_o, halted_o, wrap_o, bp_hit_o
  );
  modport master (
    output run_i, step_i, opcode_i, skip_cond_i, bp_en_i, bp_addr_i,
    input  pc_o, ctrl_o, acc_we_o, busy_o, halted_o, wrap_o, bp_hit_o
  );
`else
  modport slave (
    input  run_i, step_i, opcode_i, skip_cond_i,
    output pc_o, ctrl_o, acc_we_o, busy_o, halted_o, wrap_o
  );
  modport master (
    output run_i, step_i, opcode_i, skip_cond_i,
    input  pc_o, ctrl_o, acc_we_o, busy_o, halted_o, wrap_o
  );
`endif
endinterface

// File: rtl/aeolus_op_decode.sv
// Combinational instruction decode: one-hot strobe vector plus ALU-class and skip-class flags.
module aeolus_op_decode
  import aeolus_seq_pkg::*;
#(
  parameter int OP_WIDTH = 4
) (
  input  logic [OP_WIDTH-1:0]    i_ir,
  output logic [2**OP_WIDTH-1:0] o_onehot,
  output logic                   o_is_alu,
  output logic                   o_is_snz
);
  logic [31:0] w_ir_ext;

  assign w_ir_ext = 32'(i_ir);

  // Decode the instruction register into strobe and class flags.
  always_comb begin
    o_onehot       = '0;
    o_onehot[i_ir] = 1'b1;
    if (w_ir_ext < 32'd16) begin
      o_is_alu = op_is_alu(w_ir_ext[3:0]);
    end else begin
      o_is_alu = 1'b0;
    end
    o_is_snz = (w_ir_ext == 32'(OP_SNZA)) || (w_ir_ext == 32'(OP_SNZS));
  end
endmodule

// File: rtl/aeolus_sequencer.sv
// Aeolus multi-cycle sequencer: PC, IR and FETCH/EXEC/WB timing with registered strobes.
// Optional breakpoint hardware is built when AEOLUS_SEQ_BREAKPOINT_EN is defined.
module aeolus_sequencer
  import aeolus_seq_pkg::*;
#(
  parameter int PC_WIDTH    = 4,
  parameter int OP_WIDTH    = 4,
  parameter int EXEC_CYCLES = 1,
  parameter int WRAP_HALT   = 0
) (
  input  logic                clk,
  input  logic                reset,
  aeolus_sequencer_if.slave   bus
);
  localparam int                CTRL_W   = 2**OP_WIDTH;
  localparam int                CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [PC_WIDTH:0] INC_ONE  = (PC_WIDTH+1)'(1);
  localparam logic [PC_WIDTH:0] INC_TWO  = (PC_WIDTH+1)'(2);

  seq_state_e            r_state, w_state_nxt;
  logic [PC_WIDTH-1:0]   r_pc, w_pc_nxt;
  logic [OP_WIDTH-1:0]   r_ir, w_ir_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_skip, w_skip_nxt;
  logic                  w_bp_stop;
  logic [PC_WIDTH:0]     w_sum_wb, w_sum_out;
  logic [CTRL_W-1:0]     w_onehot;
  logic                  w_is_alu, w_is_snz;
  logic [CTRL_W-1:0]     r_ctrl, w_ctrl_nxt;
  logic                  r_acc_we, w_acc_we_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_halted, w_halted_nxt;
  logic                  r_wrap, w_wrap_nxt;
  logic                  r_bp_hit;

  // The IR only changes on FETCH, so decoding its next value lets the strobes be registered.
  assign w_ir_nxt = (r_state == S_FETCH) ? bus.opcode_i : r_ir;
  assign w_sum_wb = {1'b0, r_pc} + (r_skip ? INC_TWO : INC_ONE);

  aeolus_op_decode #(.OP_WIDTH(OP_WIDTH)) u_decode (
    .i_ir     (w_ir_nxt),
    .o_onehot (w_onehot),
    .o_is_alu (w_is_alu),
    .o_is_snz (w_is_snz)
  );

  // Next-state logic for the instruction FSM, PC, exec counter and skip flag.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_skip_nxt  = r_skip;
    w_bp_stop   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.run_i || bus.step_i) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (r_cnt == CNT_LAST) begin
          w_skip_nxt  = w_is_snz & bus.skip_cond_i;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WB;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        w_pc_nxt = w_sum_wb[PC_WIDTH-1:0];
        if ((WRAP_HALT != 0) && w_sum_wb[PC_WIDTH]) begin
          w_state_nxt = S_HALT;
        end else if (bus.run_i) begin
`ifdef AEOLUS_SEQ_BREAKPOINT_EN
          if (bus.bp_en_i && (w_sum_wb[PC_WIDTH-1:0] == bus.bp_addr_i)) begin
            w_state_nxt = S_IDLE;
            w_bp_stop   = 1'b1;
          end else begin
            w_state_nxt = S_FETCH;
          end
`else
          w_state_nxt = S_FETCH;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are computed for the upcoming state so they can come straight from flops.
  assign w_sum_out = {1'b0, r_pc} + (w_skip_nxt ? INC_TWO : INC_ONE);

  // Output pre-decode from the next state.
  always_comb begin
    w_ctrl_nxt   = '0;
    w_acc_we_nxt = 1'b0;
    w_wrap_nxt   = 1'b0;
    if (w_state_nxt == S_EXEC) begin
      w_ctrl_nxt = w_onehot;
    end else if (w_state_nxt == S_WB) begin
      w_acc_we_nxt = w_is_alu;
      w_wrap_nxt   = w_sum_out[PC_WIDTH];
    end else begin
      w_ctrl_nxt = '0;
    end
    w_busy_nxt   = (w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC) || (w_state_nxt == S_WB);
    w_halted_nxt = (w_state_nxt == S_HALT);
  end

  // State and output registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_cnt    <= '0;
      r_skip   <= 1'b0;
      r_ctrl   <= '0;
      r_acc_we <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_wrap   <= 1'b0;
      r_bp_hit <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_cnt    <= w_cnt_nxt;
      r_skip   <= w_skip_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_acc_we <= w_acc_we_nxt;
      r_busy   <= w_busy_nxt;
      r_halted <= w_halted_nxt;
      r_wrap   <= w_wrap_nxt;
      r_bp_hit <= w_bp_stop;
    end
  end

  assign bus.pc_o     = r_pc;
  assign bus.ctrl_o   = r_ctrl;
  assign bus.acc_we_o = r_acc_we;
  assign bus.busy_o   = r_busy;
  assign bus.halted_o = r_halted;
  assign bus.wrap_o   = r_wrap;
`ifdef AEOLUS_SEQ_BREAKPOINT_EN
  assign bus.bp_hit_o = r_bp_hit;
`else
  logic w_unused_bp;
  assign w_unused_bp = r_bp_hit;
`endif

endmodule
